// File: rtl/smag_pkg.sv
// Shared types and width helpers for the sign-magnitude multiplier arbiter.
package smag_pkg;

  localparam int MAG_W = 4;
  localparam int OPW   = MAG_W + 1;
  localparam int PRODW = 2 * MAG_W + 1;
  localparam int CNTW  = (MAG_W > 1) ? $clog2(MAG_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter width for a given magnitude width; never narrower than one bit.
  function automatic int cnt_width(input int mag_w);
    return (mag_w > 1) ? $clog2(mag_w) : 1;
  endfunction

endpackage

// File: rtl/smag_shift_add_core.sv
// Shift-add magnitude multiplier: one partial product per step, LSB of the multiplier first.
module smag_shift_add_core #(
  parameter int MAG_W = 4
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               start_i,
  input  logic               step_i,
  input  logic [MAG_W-1:0]   a_mag_i,
  input  logic [MAG_W-1:0]   b_mag_i,
  output logic               last_step_o,
  output logic [2*MAG_W-1:0] acc_o
);
  import smag_pkg::*;

  localparam int CNT_W = cnt_width(MAG_W);
  localparam int ACC_W = 2 * MAG_W;

  logic [MAG_W-1:0] a_q, a_d;
  logic [MAG_W-1:0] b_q, b_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] a_ext;
  logic [ACC_W-1:0] partial;
  logic [ACC_W-1:0] acc_step;

  always_comb begin
    a_ext    = {{MAG_W{1'b0}}, a_q};
    partial  = b_q[cnt_q] ? (a_ext << cnt_q) : '0;
    acc_step = acc_q + partial;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      a_d   = a_mag_i;
      b_d   = b_mag_i;
      acc_d = '0;
      cnt_d = '0;
    end else if (step_i) begin
      acc_d = acc_step;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // acc_o already includes the partial product of the current step, so the
  // caller can register the final sum on the same edge as the last step.
  assign acc_o       = acc_step;
  assign last_step_o = step_i && (cnt_q == CNT_W'(MAG_W - 1));

endmodule

// File: rtl/smag_mult_arbiter.sv
// Two-requester round-robin front end sharing one shift-add sign-magnitude multiplier.
//   state | meaning
//   IDLE  | arbitrating, at most one requester sees ready
//   CALC  | core steps through the multiplier bits, MAG_W cycles
//   DONE  | registered result on the response channel until taken
module smag_mult_arbiter #(
  parameter int MAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [MAG_W:0]   req0_a_i,
  input  logic [MAG_W:0]   req0_b_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [MAG_W:0]   req1_a_i,
  input  logic [MAG_W:0]   req1_b_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [2*MAG_W:0] rsp_prod_o,
  output logic             busy_o
);
  import smag_pkg::*;

  state_e             state_q, state_d;
  logic               last_id_q, last_id_d;
  logic               sign_q, sign_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic [2*MAG_W:0]   rsp_prod_q, rsp_prod_d;

  logic               idle;
  logic               gnt0, gnt1;
  logic               ready0, ready1;
  logic               accept;
  logic               step;
  logic               last_step;
  logic [MAG_W:0]     sel_a, sel_b;
  logic [2*MAG_W-1:0] acc;

  // With both valid, the requester that did not win last time takes the grant.
  always_comb begin
    idle   = (state_q == IDLE);
    gnt0   = req0_valid_i & (~req1_valid_i | last_id_q);
    gnt1   = req1_valid_i & (~req0_valid_i | ~last_id_q);
    ready0 = idle & gnt0;
    ready1 = idle & gnt1;
    accept = ready0 | ready1;
    sel_a  = ready1 ? req1_a_i : req0_a_i;
    sel_b  = ready1 ? req1_b_i : req0_b_i;
    step   = (state_q == CALC);
  end

  smag_shift_add_core #(
    .MAG_W (MAG_W)
  ) u_core (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .start_i     (accept),
    .step_i      (step),
    .a_mag_i     (sel_a[MAG_W-1:0]),
    .b_mag_i     (sel_b[MAG_W-1:0]),
    .last_step_o (last_step),
    .acc_o       (acc)
  );

  always_comb begin
    state_d     = state_q;
    last_id_d   = last_id_q;
    sign_d      = sign_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_prod_d  = rsp_prod_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = CALC;
          last_id_d = ready1;
          sign_d    = sel_a[MAG_W] ^ sel_b[MAG_W];
        end
      end
      CALC: begin
        if (last_step) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_id_d    = last_id_q;
          rsp_prod_d  = {sign_q, acc};
        end
      end
      DONE: begin
        if (rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      last_id_q   <= 1'b1;
      sign_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_prod_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_id_q   <= last_id_d;
      sign_q      <= sign_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_prod_q  <= rsp_prod_d;
    end
  end

  assign req0_ready_o = ready0;
  assign req1_ready_o = ready1;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_prod_o   = rsp_prod_q;
  assign busy_o       = ~idle;

endmodule

// File: tb/tb_smag_mult_arbiter.sv
// Directed bench for smag_mult_arbiter with hand-computed products.
module tb_smag_mult_arbiter;

  localparam int MAG_W = 4;

  logic             clk_i = 1'b0;
  logic             rstn_i;
  logic             req0_valid_i, req0_ready_o;
  logic [MAG_W:0]   req0_a_i, req0_b_i;
  logic             req1_valid_i, req1_ready_o;
  logic [MAG_W:0]   req1_a_i, req1_b_i;
  logic             rsp_valid_o, rsp_ready_i, rsp_id_o, busy_o;
  logic [2*MAG_W:0] rsp_prod_o;

  int checks = 0;
  int errors = 0;

  smag_mult_arbiter #(.MAG_W(MAG_W)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .req0_valid_i (req0_valid_i),
    .req0_ready_o (req0_ready_o),
    .req0_a_i     (req0_a_i),
    .req0_b_i     (req0_b_i),
    .req1_valid_i (req1_valid_i),
    .req1_ready_o (req1_ready_o),
    .req1_a_i     (req1_a_i),
    .req1_b_i     (req1_b_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_id_o     (rsp_id_o),
    .rsp_prod_o   (rsp_prod_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drop_reqs();
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    req0_a_i = 5'b1_1010;
    req0_b_i = 5'b0_1101;
    req1_a_i = 5'b0_1001;
    req1_b_i = 5'b1_0110;
  endtask

  task automatic wait_rsp(input int max, output int n);
    n = 0;
    while (!rsp_valid_o && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    rsp_ready_i = 1'b0;
    drop_reqs();
    #3;
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rsp_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (rsp_prod_o !== 9'b0) begin errors++; $display("FAIL reset_prod: got %b want 0", rsp_prod_o); end
    checks++; if (rsp_id_o !== 1'b0) begin errors++; $display("FAIL reset_id: got %b want 0", rsp_id_o); end
    @(negedge clk_i);
    rstn_i = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int n;
    req0_valid_i = 1'b1;
    req0_a_i = 5'b0_0101;
    req0_b_i = 5'b1_0011;
    #1;
    checks++; if ({req0_ready_o, req1_ready_o} !== 2'b10) begin errors++; $display("FAIL single_ready: got %b want 10", {req0_ready_o, req1_ready_o}); end
    tick();
    drop_reqs();
    checks++; if (busy_o !== 1'b1 || req0_ready_o !== 1'b0) begin errors++; $display("FAIL single_busy: got busy=%b rdy=%b want busy=1 rdy=0", busy_o, req0_ready_o); end
    wait_rsp(20, n);
    checks++; if (n !== 4 || rsp_valid_o !== 1'b1) begin errors++; $display("FAIL single_latency: got %0d cycles valid=%b want 4 valid=1", n, rsp_valid_o); end
    checks++; if (rsp_id_o !== 1'b0) begin errors++; $display("FAIL single_id: got %b want 0", rsp_id_o); end
    checks++; if (rsp_prod_o !== 9'b1_0000_1111) begin errors++; $display("FAIL single_prod: got %b want 100001111", rsp_prod_o); end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    checks++; if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL single_handshake: got valid=%b busy=%b want 0 0", rsp_valid_o, busy_o); end
    checks++; if (rsp_prod_o !== 9'b1_0000_1111) begin errors++; $display("FAIL single_prod_held: got %b want 100001111", rsp_prod_o); end
  endtask

  task automatic test_fullscale();
    int n;
    req1_valid_i = 1'b1;
    req1_a_i = 5'b0_1111;
    req1_b_i = 5'b1_1111;
    #1;
    checks++; if ({req0_ready_o, req1_ready_o} !== 2'b01) begin errors++; $display("FAIL full_ready: got %b want 01", {req0_ready_o, req1_ready_o}); end
    tick();
    drop_reqs();
    wait_rsp(20, n);
    checks++; if (n !== 4 || rsp_valid_o !== 1'b1) begin errors++; $display("FAIL full_latency: got %0d cycles want 4", n); end
    checks++; if (rsp_id_o !== 1'b1) begin errors++; $display("FAIL full_id: got %b want 1", rsp_id_o); end
    checks++; if (rsp_prod_o !== 9'b1_1110_0001) begin errors++; $display("FAIL full_prod: got %b want 111100001", rsp_prod_o); end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_fairness();
    int nrsp;
    int prev_cyc;
    logic [2*MAG_W:0] exp_prod;
    rstn_i = 1'b0;
    #2;
    req0_valid_i = 1'b1; req0_a_i = 5'b0_0010; req0_b_i = 5'b0_0011;
    req1_valid_i = 1'b1; req1_a_i = 5'b1_0111; req1_b_i = 5'b0_0101;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rstn_i = 1'b1;
    nrsp = 0;
    prev_cyc = 0;
    for (int cyc = 0; cyc < 40 && nrsp < 4; cyc++) begin
      tick();
      if (rsp_valid_o) begin
        exp_prod = (nrsp % 2 == 0) ? 9'b0_0000_0110 : 9'b1_0010_0011;
        checks++; if (rsp_id_o !== 1'((nrsp % 2))) begin errors++; $display("FAIL fair_id%0d: got %b want %0d", nrsp, rsp_id_o, nrsp % 2); end
        checks++; if (rsp_prod_o !== exp_prod) begin errors++; $display("FAIL fair_prod%0d: got %b want %b", nrsp, rsp_prod_o, exp_prod); end
        if (nrsp > 0) begin
          checks++; if (cyc - prev_cyc !== 6) begin errors++; $display("FAIL fair_period%0d: got %0d want 6", nrsp, cyc - prev_cyc); end
        end
        prev_cyc = cyc;
        nrsp++;
      end
    end
    checks++; if (nrsp !== 4) begin errors++; $display("FAIL fair_count: got %0d responses want 4", nrsp); end
    drop_reqs();
    tick();
    rsp_ready_i = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    req1_valid_i = 1'b1;
    req1_a_i = 5'b0_0110;
    req1_b_i = 5'b0_0010;
    #1;
    checks++; if (req1_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b want 1", req1_ready_o); end
    tick();
    drop_reqs();
    wait_rsp(20, n);
    checks++; if (n !== 4 || rsp_valid_o !== 1'b1) begin errors++; $display("FAIL bp_latency: got %0d cycles want 4", n); end
    req0_valid_i = 1'b1;
    req1_valid_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid_o !== 1'b1 || rsp_prod_o !== 9'b0_0000_1100 || rsp_id_o !== 1'b1 ||
          req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0 || busy_o !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold cycle %0d: got v=%b p=%b id=%b r0=%b r1=%b busy=%b want 1 000001100 1 0 0 1",
                 i, rsp_valid_o, rsp_prod_o, rsp_id_o, req0_ready_o, req1_ready_o, busy_o);
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold_total: got %0d bad cycles want 0", bad); end
    drop_reqs();
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    checks++; if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL bp_release: got valid=%b busy=%b want 0 0", rsp_valid_o, busy_o); end
    checks++; if (rsp_prod_o !== 9'b0_0000_1100 || rsp_id_o !== 1'b1) begin errors++; $display("FAIL bp_held_after: got %b id=%b want 000001100 id=1", rsp_prod_o, rsp_id_o); end
    tick();
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL bp_single_hs: got %b want 0", rsp_valid_o); end
  endtask

  task automatic test_zero_sign();
    int n;
    req0_valid_i = 1'b1;
    req0_a_i = 5'b1_0000;
    req0_b_i = 5'b0_0111;
    #1;
    checks++; if (req0_ready_o !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b want 1", req0_ready_o); end
    tick();
    drop_reqs();
    wait_rsp(20, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL zero_latency: got %0d want 4", n); end
    checks++; if (rsp_prod_o !== 9'b1_0000_0000 || rsp_id_o !== 1'b0) begin errors++; $display("FAIL zero_prod: got %b id=%b want 100000000 id=0", rsp_prod_o, rsp_id_o); end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    int seen;
    req0_valid_i = 1'b1;
    req0_a_i = 5'b0_0101;
    req0_b_i = 5'b0_0101;
    tick();
    drop_reqs();
    tick();
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy_o); end
    #2;
    rstn_i = 1'b0;
    #1;
    checks++; if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL mid_async: got valid=%b busy=%b want 0 0", rsp_valid_o, busy_o); end
    tick();
    rstn_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_valid_o !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_rsp: got %0d valid cycles want 0", seen); end
    req0_valid_i = 1'b1; req0_a_i = 5'b0_0011; req0_b_i = 5'b0_0011;
    req1_valid_i = 1'b1; req1_a_i = 5'b0_0001; req1_b_i = 5'b0_0001;
    #1;
    checks++; if ({req0_ready_o, req1_ready_o} !== 2'b10) begin errors++; $display("FAIL mid_arb: got %b want 10", {req0_ready_o, req1_ready_o}); end
    tick();
    drop_reqs();
    wait_rsp(20, n);
    checks++; if (n !== 4 || rsp_valid_o !== 1'b1) begin errors++; $display("FAIL mid_latency: got %0d want 4", n); end
    checks++; if (rsp_prod_o !== 9'b0_0000_1001 || rsp_id_o !== 1'b0) begin errors++; $display("FAIL mid_prod: got %b id=%b want 000001001 id=0", rsp_prod_o, rsp_id_o); end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fullscale();
    test_fairness();
    test_backpressure();
    test_zero_sign();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/smag_mult_arbiter.md
Name: smag_mult_arbiter

Overview:
Shares one sequential shift-add sign-magnitude multiplier between two requesters. Round-robin arbitration selects the requester, and a small FSM sequences the shift-add datapath over MAG_W cycles. The result is returned on a single response channel tagged with the requester ID. The block sits between the operand producers and the result consumer as the only multiply resource in the arithmetic subsystem.

Parameters:
MAG_W, 4, magnitude width per operand; operands are MAG_W+1 bits (MSB = sign), product is 2*MAG_W+1 bits (MSB = sign).

Ports:
clk_i  input  1  system clock, rising edge
rstn_i  input  1  reset; one clock, reset is asynchronous and active-low
req0_valid_i  input  1  requester 0 has operands
req0_ready_o  output  1  requester 0 operands accepted this cycle when valid & ready
req0_a_i  input  MAG_W+1  requester 0 multiplicand, sign-magnitude
req0_b_i  input  MAG_W+1  requester 0 multiplier, sign-magnitude
req1_valid_i, req1_ready_o, req1_a_i, req1_b_i  same as requester 0, for requester 1
rsp_valid_o  output  1  result available
rsp_ready_i  input  1  consumer takes result
rsp_id_o  output  1  requester that owns the result (0/1)
rsp_prod_o  output  2*MAG_W+1  product, sign-magnitude
busy_o  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, rstn_i=0):
  - state=IDLE, acc=0, cnt=0, last_id=1 (req0 wins first).
  - rsp_valid_o=0, rsp_id_o=0, rsp_prod_o=0, busy_o=0.
  - Any operation in flight is discarded with no response.
- States: IDLE, CALC, DONE.
- IDLE arbitration (combinational ready):
  - Only one valid: that requester is granted.
  - Both valid: grant the requester != last_id.
  - reqN_ready_o=1 only for the granted requester. Both readys are 0 outside IDLE.
- Acceptance on rising edge k (IDLE, valid & ready):
  - Capture a/b magnitudes, sign = a[MAG_W] XOR b[MAG_W], and id.
  - Set last_id=id, acc=0, cnt=0, state=CALC.
- CALC, edges k+1 .. k+MAG_W:
  - If b_mag[cnt]=1, acc += a_mag << cnt. acc is 2*MAG_W bits wide, so no overflow is possible.
  - cnt increments by 1 each edge.
  - On the edge where cnt=MAG_W-1 is processed, state becomes DONE.
- DONE:
  - rsp_valid_o=1 from edge k+MAG_W (latency MAG_W cycles).
  - rsp_prod_o = {sign, acc}; rsp_id_o = id.
  - All response outputs are registered and held stable while rsp_ready_i=0.
  - On the rsp_valid_o & rsp_ready_i edge: state=IDLE and rsp_valid_o=0. rsp_prod_o and rsp_id_o keep their last values.
- No new request is accepted in the same cycle as the response handshake. Minimum period is MAG_W+2 cycles per operation.
- Sign rule: sign is always the XOR of the operand signs. There is no negative-zero normalisation, so a zero magnitude can carry sign 1.
- Operand inputs are sampled only at the acceptance edge. Changes while not ready, or after acceptance, are ignored.
- A requester may hold valid indefinitely; round-robin guarantees neither requester starves.
- rsp_ready_i is ignored outside DONE.

Decomposition:
- Package smag_pkg:
  - state enum (IDLE, CALC, DONE).
  - MAG_W default.
  - Width localparams: OPW=MAG_W+1, PRODW=2*MAG_W+1, CNTW=$clog2(MAG_W).
- Sub-module smag_shift_add_core:
  - Owns acc, cnt, and the captured a_mag/b_mag.
  - Inputs: start, step. Outputs: last_step, acc.
- Top level holds the arbiter, the FSM, and the response registers.

Test Plan:
1. Single request: req0 only, a=+5 (5'b0_0101), b=−3 (5'b1_0011). Expect rsp_valid_o after exactly 4 cycles, rsp_id_o=0, rsp_prod_o=9'b1_0000_1111 (−15).
2. Full-scale: req1 only, a=+15 (5'b0_1111), b=−15 (5'b1_1111). Expect rsp_id_o=1, rsp_prod_o=9'b1_1110_0001 (−225).
3. Fairness: both valid continuously after reset with distinct operands, rsp_ready_i=1. Expect grant order 0,1,0,1, one response per 6 cycles, each rsp_id_o matching its product.
4. Backpressure: hold rsp_ready_i=0 for 10 cycles in DONE. Expect rsp_valid_o=1 with rsp_prod_o/rsp_id_o stable, both reqN_ready_o=0, busy_o=1. Release gives one handshake, then IDLE.
5. Zero/sign: a=−0 (5'b1_0000), b=+7 (5'b0_0111). Expect rsp_prod_o=9'b1_0000_0000.
6. Reset mid-operation: drop rstn_i during the second CALC cycle. Expect rsp_valid_o=0 and busy_o=0 asynchronously, and no response after release. A following req0 (+3 × +3) gives 9'b0_0000_1001, and req0 wins arbitration because last_id reset to 1.
